// File: rtl/printf_arbiter.sv
// rtl/printf_arbiter.sv - round-robin arbiter funnelling NUM_REQ printf sources into one 2-deep output FIFO
module printf_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 144
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            in_pending,
    input  logic [NUM_REQ-1:0]            in_enq__ENA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_enq__v,
    output logic [NUM_REQ-1:0]            in_enq__RDY,
    output logic                          out_enq__ENA,
    output logic [DATA_WIDTH-1:0]         out_enq__v,
    input  logic                          out_enq__RDY,
    output logic [31:0]                   beat_count,
    output logic                          proto_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_valid;
    logic [PTR_W:0]        scan_idx;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            fifo_count;

    logic                  accept;
    logic                  pop;
    logic                  bad_ena;
    logic [DATA_WIDTH-1:0] win_data;

    // Scan offsets from the top down so the lowest offset from rr_ptr is the last to win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_idx >= (PTR_W + 1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W + 1)'(NUM_REQ);
            end
            if (in_pending[scan_idx[PTR_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // Grant depends only on registered state and in_pending, never on any ENA.
    always_comb begin
        in_enq__RDY = '0;
        if (!RST && fifo_count != 2'd2 && win_valid) begin
            in_enq__RDY[win_idx] = 1'b1;
        end
    end

    assign win_data     = in_enq__v[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign accept       = |(in_enq__ENA & in_enq__RDY);
    assign bad_ena      = |(in_enq__ENA & ~in_enq__RDY);
    assign pop          = !RST && fifo_count != 2'd0 && out_enq__RDY;
    assign out_enq__ENA = pop;
    assign out_enq__v   = (!RST && fifo_count != 2'd0) ? fifo_mem[rd_sel] : '0;

    always_ff @(posedge CLK) begin
        if (accept) begin
            fifo_mem[wr_sel] <= win_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr     <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fifo_count <= 2'd0;
            beat_count <= 32'd0;
            proto_err  <= 1'b0;
        end else begin
            if (accept) begin
                wr_sel     <= ~wr_sel;
                beat_count <= beat_count + 32'd1;
                rr_ptr     <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (bad_ena) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_printf_arbiter.sv
// tb/tb_printf_arbiter.sv - scoreboard bench for printf_arbiter against a queue-based reference model
module tb_printf_arbiter;
    localparam int N  = 4;
    localparam int DW = 144;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      in_pending;
    logic [N-1:0]      in_enq__ENA;
    logic [N*DW-1:0]   in_bus;
    logic [N-1:0]      in_enq__RDY;
    logic              out_enq__ENA;
    logic [DW-1:0]     out_bus;
    logic              out_enq__RDY;
    logic [31:0]       beat_count;
    logic              proto_err;

    printf_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_pending   (in_pending),
        .in_enq__ENA  (in_enq__ENA),
        .in_enq__v    (in_bus),
        .in_enq__RDY  (in_enq__RDY),
        .out_enq__ENA (out_enq__ENA),
        .out_enq__v   (out_bus),
        .out_enq__RDY (out_enq__RDY),
        .beat_count   (beat_count),
        .proto_err    (proto_err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            stamp;
    } exp_t;

    exp_t          sb[$];
    int            m_rr   = 0;
    logic [31:0]   m_cnt  = 0;
    logic          m_perr = 0;
    logic [DW-1:0] src_beat [N];

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference grant: first pending source at or after m_rr, if the 2-deep FIFO has room.
    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r;
        r = '0;
        if (!RST && sb.size() < 2) begin
            for (int k = 0; k < N; k++) begin
                if (r == '0 && in_pending[(m_rr + k) % N]) r[(m_rr + k) % N] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic step(input logic [N-1:0] pend, input logic [N-1:0] manual_ena,
                        input bit use_auto, input logic ordy, input bit rnd, input int drop_pct);
        logic [N-1:0] erdy;
        logic [N-1:0] ena;
        @(negedge CLK);
        in_pending   = pend;
        out_enq__RDY = ordy;
        in_enq__ENA  = '0;
        for (int i = 0; i < N; i++) begin
            if (rnd) src_beat[i] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            else     src_beat[i] = {16'(i), 128'(32'hA0 + i)};
            in_bus[i*DW +: DW] = src_beat[i];
        end
        #1;
        erdy = model_rdy();
        check("in_rdy", DW'(in_enq__RDY), DW'(erdy));
        check("beat_count", DW'(beat_count), DW'(m_cnt));
        check("proto_err", DW'(proto_err), DW'(m_perr));
        ena = use_auto ? erdy : manual_ena;
        if (use_auto && drop_pct > 0 && ($urandom % 100) < drop_pct) ena = '0;
        in_enq__ENA = ena;
        if (|(ena & ~erdy)) m_perr = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ena[i] && erdy[i]) begin
                sb.push_back('{data: src_beat[i], stamp: cyc});
                m_rr  = (i + 1) % N;
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic do_reset(input logic [N-1:0] pend);
        @(negedge CLK);
        RST          = 1'b1;
        in_pending   = pend;
        in_enq__ENA  = '0;
        out_enq__RDY = 1'b1;
        sb.delete();
        m_rr   = 0;
        m_cnt  = 0;
        m_perr = 1'b0;
        #1;
        check("rst_rdy", DW'(in_enq__RDY), '0);
        check("rst_out_ena", DW'(out_enq__ENA), '0);
        check("rst_out_v", out_bus, '0);
        check("rst_beat_count", DW'(beat_count), '0);
        check("rst_proto_err", DW'(proto_err), '0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT delivers a beat.
    initial begin
        bit old;
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                check("mon_rst_ena", DW'(out_enq__ENA), '0);
            end else begin
                old = sb.size() > 0 && sb[0].stamp < cyc;
                check("out_ena", DW'(out_enq__ENA), DW'(out_enq__RDY && old));
                if (out_enq__ENA && old) begin
                    check("out_data", out_bus, sb[0].data);
                    void'(sb.pop_front());
                end else if (!old) begin
                    check("out_empty_v", out_bus, '0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        in_pending   = '1;
        in_enq__ENA  = '0;
        in_bus       = '0;
        out_enq__RDY = 1'b0;

        do_reset(4'hF);
        step(4'hF, '0, 0, 1'b1, 0, 0);
        check("post_reset_rdy", DW'(in_enq__RDY), DW'(4'b0001));

        for (int k = 0; k < 8; k++) begin
            step(4'hF, '0, 1, 1'b1, 0, 0);
            check("rr_order", DW'(in_enq__RDY), DW'(4'b0001 << (k % 4)));
        end
        step(4'h0, '0, 0, 1'b1, 0, 0);
        check("rr_beats", DW'(beat_count), DW'(8));
        repeat (2) step(4'h0, '0, 0, 1'b1, 0, 0);

        repeat (4) step(4'b0100, '0, 1, 1'b0, 0, 0);
        step(4'b0100, '0, 1, 1'b0, 0, 0);
        check("bp_rdy_low", DW'(in_enq__RDY), '0);
        check("bp_beats", DW'(beat_count), DW'(10));
        repeat (4) step(4'b0100, '0, 1, 1'b1, 0, 0);
        repeat (3) step(4'h0, '0, 0, 1'b1, 0, 0);

        step(4'b0010, '0, 1, 1'b1, 0, 0);
        step(4'b1010, '0, 1, 1'b1, 0, 0);
        check("sparse_1", DW'(in_enq__RDY), DW'(4'b1000));
        step(4'b1010, '0, 1, 1'b1, 0, 0);
        check("sparse_2", DW'(in_enq__RDY), DW'(4'b0010));
        step(4'b1010, '0, 1, 1'b1, 0, 0);
        check("sparse_3", DW'(in_enq__RDY), DW'(4'b1000));
        repeat (2) step(4'h0, '0, 0, 1'b1, 0, 0);

        step(4'b0100, 4'b0001, 0, 1'b1, 0, 0);
        check("perr_rdy", DW'(in_enq__RDY), DW'(4'b0100));
        step(4'h0, '0, 0, 1'b1, 0, 0);
        check("perr_set", DW'(proto_err), DW'(1));
        repeat (3) step(4'h0, '0, 0, 1'b1, 0, 0);
        check("perr_sticky", DW'(proto_err), DW'(1));

        repeat (300) step(4'($urandom), '0, 1, 1'($urandom), 1, 30);

        repeat (3) step(4'hF, '0, 1, 1'b0, 1, 0);
        do_reset(4'hF);
        step(4'hF, '0, 0, 1'b1, 0, 0);
        check("midrst_rdy", DW'(in_enq__RDY), DW'(4'b0001));

        repeat (200) step(4'($urandom), '0, 1, ($urandom % 4) != 0, 1, 20);
        repeat (4) step(4'h0, '0, 0, 1'b1, 0, 0);
        check("drained", DW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
